// File: rtl/fifo_8bits_if.sv
// ---------------------------------------------------------------------------
// fifo_8bits_if -- bus bundle between the byte FIFO and its neighbours.
//
// Parameter:
//   DEPTH        number of 8-bit entries (sets the width of count)
// Signals:
//   data_in      byte from the upstream lane mux
//   push         write strobe (mux outValid)
//   pop          read request from the downstream consumer
//   data_out     registered read data
//   valid_out    data_out carries a byte popped in the previous cycle
//   full/empty   occupancy flags
//   almost_full/almost_empty  threshold flags
//   count        current occupancy, 0..DEPTH
//   overflow/underflow  sticky error flags (only with FIFO_ERR_FLAGS_EN)
// Modports:
//   master       producer/consumer side (drives data_in, push, pop)
//   slave        FIFO side
// ---------------------------------------------------------------------------
interface fifo_8bits_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    data_in;
    logic          push;
    logic          pop;
    logic [7:0]    data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;

    modport master (
        output data_in, push, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
    modport slave (
        input  data_in, push, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
`else
    modport master (
        output data_in, push, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               count
    );
    modport slave (
        input  data_in, push, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               count
    );
`endif
endinterface

// File: rtl/fifo_8bits.sv
// ---------------------------------------------------------------------------
// fifo_8bits -- synchronous byte FIFO (circular buffer) with registered read
// data and occupancy/threshold flags.
//
// Parameters:
//   DEPTH         entries, power of two in 4..64 (default 8)
//   ALMOST_FULL   almost_full  when count >= ALMOST_FULL  (default 6)
//   ALMOST_EMPTY  almost_empty when count <= ALMOST_EMPTY (default 2)
// Ports:
//   clk           rising-edge clock
//   reset_L       asynchronous active-low reset (clears pointers, count,
//                 data_out, valid_out; storage array is not cleared)
//   bus           fifo_8bits_if.slave (data_in, push, pop, data_out,
//                 valid_out, full, empty, almost_full, almost_empty, count)
// Build option:
//   FIFO_ERR_FLAGS_EN  adds sticky overflow/underflow outputs on bus
// ---------------------------------------------------------------------------
module fifo_8bits #(
    parameter int DEPTH        = 8,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic         clk,
    input  logic         reset_L,
    fifo_8bits_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valid_out_q, valid_out_d;
    logic          full, empty;
    logic          wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A push at full is still taken when a pop frees the slot in the same
    // cycle; a pop at empty is never taken, so there is no pass-through.
    assign rd_en = bus.pop && !empty;
    assign wr_en = bus.push && (!full || bus.pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Storage has no reset; stale bytes are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(ALMOST_FULL));
    assign bus.almost_empty = (count_q <= CW'(ALMOST_EMPTY));

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (bus.push && full && !bus.pop);
        underflow_d = underflow_q || (bus.pop && empty);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_8bits.sv
// ---------------------------------------------------------------------------
// tb_fifo_8bits -- directed self-checking bench for fifo_8bits (DEPTH=8).
// A queue holds the bytes the FIFO should contain; popped bytes become the
// expected data_out one cycle later. Flags are derived from the queue size.
// ---------------------------------------------------------------------------
module tb_fifo_8bits;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk;
    logic reset_L;

    fifo_8bits_if #(.DEPTH(DEPTH)) bus ();

    fifo_8bits #(
        .DEPTH        (DEPTH),
        .ALMOST_FULL  (AF),
        .ALMOST_EMPTY (AE)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned tests;
    int unsigned fails;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_data;
    logic        exp_valid;
    logic        exp_ovf;
    logic        exp_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".valid"}, 32'(bus.valid_out), 32'(exp_valid));
        check({tag, ".data"},  32'(bus.data_out),  32'(exp_data));
        check({tag, ".count"}, 32'(bus.count),     32'(n));
        check({tag, ".full"},  32'(bus.full),      32'(n == DEPTH));
        check({tag, ".empty"}, 32'(bus.empty),     32'(n == 0));
        check({tag, ".af"},    32'(bus.almost_full),  32'(n >= AF));
        check({tag, ".ae"},    32'(bus.almost_empty), 32'(n <= AE));
`ifdef FIFO_ERR_FLAGS_EN
        check({tag, ".ovf"},   32'(bus.overflow),  32'(exp_ovf));
        check({tag, ".unf"},   32'(bus.underflow), 32'(exp_unf));
`endif
    endtask

    // Called #1 after a rising edge; applies inputs for the next edge.
    task automatic step(input string tag, input logic p, input logic q, input logic [7:0] d);
        int  n;
        logic do_pop;
        logic do_push;
        n       = exp_q.size();
        do_pop  = q && (n > 0);
        do_push = p && ((n < DEPTH) || do_pop);
        if (p && n == DEPTH && !q) exp_ovf = 1'b1;
        if (q && n == 0)           exp_unf = 1'b1;
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        exp_valid   = do_pop;
        if (do_pop)  exp_data = exp_q.pop_front();
        if (do_push) exp_q.push_back(d);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = 8'h00;
        model_reset();

        // Reset held across edges: outputs cleared, flags in reset state.
        reset_L = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        reset_L = 1'b1;

        // Pop at empty is ignored; first push after reset is accepted.
        step("pop_empty", 1'b0, 1'b1, 8'h00);
        step("push_a1", 1'b1, 1'b0, 8'hA1);
        step("push_b2", 1'b1, 1'b0, 8'hB2);
        step("push_c3", 1'b1, 1'b0, 8'hC3);
        step("pop_a1",  1'b0, 1'b1, 8'h00);
        step("pop_b2",  1'b0, 1'b1, 8'h00);
        step("pop_c3",  1'b0, 1'b1, 8'h00);
        step("idle0",   1'b0, 1'b0, 8'h00);

        // Fill to full, overflow attempt, drain.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i));
        step("push_ff_drop", 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00);
        step("idle1", 1'b0, 1'b0, 8'h00);

        // Simultaneous push+pop at count 0, 4 and 8.
        step("pp_at0", 1'b1, 1'b1, 8'h30);
        for (int i = 0; i < 3; i++) step("to4", 1'b1, 1'b0, 8'(8'h40 + i));
        step("pp_at4", 1'b1, 1'b1, 8'h44);
        for (int i = 0; i < 4; i++) step("to8", 1'b1, 1'b0, 8'(8'h50 + i));
        step("pp_at8", 1'b1, 1'b1, 8'h58);
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b1, 8'h00);
        step("idle2", 1'b0, 1'b0, 8'h00);

        // Pointer wrap via alternating pairs, then mid-stream async reset.
        for (int i = 0; i < 20; i++) begin
            step("wrap_push", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            step("wrap_pop",  1'b0, 1'b1, 8'h00);
        end
        step("pre_push0", 1'b1, 1'b0, 8'h9C);
        step("pre_push1", 1'b1, 1'b0, 8'h9D);
        step("pre_pop",   1'b1, 1'b1, 8'h9E);
        #2;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        reset_L  = 1'b0;
        model_reset();
        #1;
        check_state("async_reset");
        @(posedge clk);
        #1;
        check_state("reset_hold");
        reset_L = 1'b1;
        step("post_push", 1'b1, 1'b0, 8'h5A);
        step("post_pop",  1'b0, 1'b1, 8'h00);
        step("idle3",     1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
